prbs_pattern_checker: RTL and testbench
=======================================

// Module: prbs_pattern_checker
// PURPOSE
//  - Receive end of the PRBS link: Avalon-ST sink paired with prbs_pattern_generator.
//  - Regenerates the expected PRBS sequence from a CSR-programmed seed and polynomial.
//  - Compares every accepted beat against it and counts beats and errors.
//  - Sits on the same CSR bus as the generator and reports link integrity to software.
// PARAMETERS
//  DATA_WIDTH  32  sink data width in bits; legal values 8..64.
// PORTS
//  clk             in   1           single clock; all logic is on its rising edge.
//  reset           in   1           asynchronous assert, active-low (0 = reset).
//  csr_address     in   3           CSR word address.
//  csr_writedata   in   32          CSR write data.
//  csr_write       in   1           CSR write strobe.
//  csr_read        in   1           CSR read strobe.
//  csr_byteenable  in   4           write byte lanes; bit n enables bits [8n+7:8n].
//  csr_readdata    out  32          registered read data.
//  snk_data        in   DATA_WIDTH  received PRBS word.
//  snk_valid       in   1           snk_data is valid.
//  snk_ready       out  1           checker accepts a beat this cycle.
// BEHAVIOUR
//  - Reset: csr_readdata=0, snk_ready=0, FSM=IDLE, all CSRs=0 except SEED=64'h1 and POLY=64'h0.
//  - CSR map (byteenable applies to every write; RO registers ignore writes):
//      0 PAYLOAD_LENGTH RW: number of beats to check; 0 = run continuously.
//      1 BEAT_COUNT     RO: beats accepted since the last start.
//      2 CONTROL        W:  bit24 start, bit25 stop, bit0 clear counts; all self-clearing.
//                       R:  bit24 running, bit8 done, bit9 error_seen (ERROR_COUNT!=0).
//      3 ERROR_COUNT    RO: errored beats; saturates at 32'hFFFFFFFF.
//      4/5 POLY[31:0]/[63:32] RW.   6/7 SEED[31:0]/[63:32] RW.
//  - Read latency: csr_readdata is valid 1 cycle after csr_read; it holds its value otherwise.
//  - LFSR model (same as the generator):
//      - 64-bit state S; one step: fb = ^(S & POLY), S <= {S[62:0], fb}.
//      - Expected word E = S[DATA_WIDTH-1:0].
//      - After each accepted beat, S advances DATA_WIDTH steps in one cycle (unrolled logic).
//  - Beat acceptance: a beat is accepted when snk_valid & snk_ready.
//      - snk_ready is a registered output; it is 1 only in RUN.
//      - On each accepted beat: BEAT_COUNT+=1 (wraps at 2^32); if snk_data!=E, the error count increments.
//  - FSM:
//      - IDLE: start -> load S=SEED, clear BEAT_COUNT and ERROR_COUNT -> RUN.
//      - RUN: an accepted beat with PAYLOAD_LENGTH!=0 and BEAT_COUNT==PAYLOAD_LENGTH-1 -> DONE.
//        stop -> IDLE. start -> reload S, clear counts, stay in RUN (restart).
//      - DONE: done=1, snk_ready=0. start -> RUN (reload). stop -> IDLE.
//  - snk_ready drops in the cycle after the final accepted beat; a beat offered then is not consumed.
//  - start and stop written together: start wins.
//  - clear while in RUN zeroes the counts; a beat accepted in that same cycle counts as beat 1.
//  - Writing SEED or POLY while in RUN takes effect at the next start only (shadowed).
//  - reset mid-run: immediate return to reset values; any partial beat is discarded.
// CONFIGURATION
//  PRBS_CHK_BIT_ERR_EN:
//    - defined: ERROR_COUNT adds popcount(snk_data^E) per beat (bit errors), saturating.
//    - undefined: ERROR_COUNT adds 1 per mismatching beat.
//    - The CSR map is identical in both builds.
// TESTING
//  1 Reset: hold reset=0 for 3 clks -> snk_ready=0, CSR reads of 0,1,3 return 0, SEED read returns 1.
//  2 Clean run: POLY=64'h0000_0000_6000_0000, SEED=1, LEN=32, start (addr2, be=4'b1000, 32'h01000000),
//    drive 32 model words -> BEAT_COUNT=32, ERROR_COUNT=0, done=1, snk_ready=0 after beat 32.
//  3 Error injection: as test 2, flip bit 0 of beat 5 and bits 3:0 of beat 20
//    -> ERROR_COUNT=2 (macro undefined) or 5 (macro defined), error_seen=1.
//  4 Backpressure/gaps: snk_valid toggles 1010..., LEN=16 -> exactly 16 beats accepted, 0 errors.
//  5 Continuous + stop: LEN=0, 100 beats, then write stop -> state IDLE, BEAT_COUNT=100, snk_ready=0 next clk.
//  6 Restart/reset: start again at beat 10 of a run -> counts 0, checking restarts from SEED;
//    reset=0 mid-run -> all reset values.

Source files
------------

// File: rtl/prbs_pattern_checker.sv
// prbs_pattern_checker
//   Receive end of a PRBS link. Regenerates the expected sequence from a
//   CSR-programmed seed/polynomial, compares every accepted beat and counts
//   beats and errors for software.
//
//   Optional build macro: PRBS_CHK_BIT_ERR_EN
//     defined   -> ERROR_COUNT accumulates bit errors (popcount of mismatch)
//     undefined -> ERROR_COUNT accumulates errored beats
//
// Ports
//   clk, reset        single clock, async active-low reset
//   csr_*             CSR slave (3-bit word address, byte enables,
//                     registered read data with 1-cycle latency)
//   snk_data/valid    Avalon-ST sink input
//   snk_ready         registered; high only while running
module prbs_pattern_checker #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            csr_address,
  input  logic [31:0]           csr_writedata,
  input  logic                  csr_write,
  input  logic                  csr_read,
  input  logic [3:0]            csr_byteenable,
  output logic [31:0]           csr_readdata,
  input  logic [DATA_WIDTH-1:0] snk_data,
  input  logic                  snk_valid,
  output logic                  snk_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0] payload_len, beat_cnt, err_cnt;
  logic [63:0] poly, seed;
  // Working copies loaded on start; CSR writes mid-run only affect the next start.
  logic [63:0] poly_act, lfsr;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // DATA_WIDTH LFSR steps per accepted beat, fully unrolled.
  function automatic logic [63:0] lfsr_adv(input logic [63:0] s,
                                           input logic [63:0] p);
    logic [63:0] r;
    r = s;
    for (int i = 0; i < DATA_WIDTH; i++)
      r = {r[62:0], ^(r & p)};
    return r;
  endfunction

  logic wr_ctrl, start, stop, clr, acc, last_beat;
  logic [DATA_WIDTH-1:0] diff;
  logic [31:0] err_inc, err_sat;
  logic [32:0] err_sum;

  assign wr_ctrl = csr_write && (csr_address == 3'd2);
  assign start   = wr_ctrl && csr_byteenable[3] && csr_writedata[24];
  assign stop    = wr_ctrl && csr_byteenable[3] && csr_writedata[25];
  assign clr     = wr_ctrl && csr_byteenable[0] && csr_writedata[0];

  assign acc       = snk_valid && snk_ready;
  assign diff      = snk_data ^ lfsr[DATA_WIDTH-1:0];
  assign last_beat = acc && (payload_len != 32'd0) && (beat_cnt == payload_len - 32'd1);

`ifdef PRBS_CHK_BIT_ERR_EN
  assign err_inc = 32'($countones(diff));
`else
  assign err_inc = {31'd0, |diff};
`endif

  // A clear coinciding with an accepted beat restarts the count from that beat.
  assign err_sum = clr ? {1'b0, err_inc} : ({1'b0, err_cnt} + {1'b0, err_inc});
  assign err_sat = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (start)          state_nxt = RUN;
        else if (stop)      state_nxt = IDLE;
        else if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        if (start)     state_nxt = RUN;
        else if (stop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      snk_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      snk_ready <= (state_nxt == RUN);
    end
  end

  // Datapath: start has priority; a beat landing in the start cycle is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr     <= 64'd0;
      poly_act <= 64'd0;
      beat_cnt <= 32'd0;
      err_cnt  <= 32'd0;
    end else if (start) begin
      lfsr     <= seed;
      poly_act <= poly;
      beat_cnt <= 32'd0;
      err_cnt  <= 32'd0;
    end else if (acc) begin
      lfsr     <= lfsr_adv(lfsr, poly_act);
      beat_cnt <= (clr ? 32'd0 : beat_cnt) + 32'd1;
      err_cnt  <= err_sat;
    end else if (clr) begin
      beat_cnt <= 32'd0;
      err_cnt  <= 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      payload_len <= 32'd0;
      poly        <= 64'd0;
      seed        <= 64'd1;
    end else if (csr_write) begin
      case (csr_address)
        3'd0: payload_len  <= be_merge(payload_len,  csr_writedata, csr_byteenable);
        3'd4: poly[31:0]   <= be_merge(poly[31:0],   csr_writedata, csr_byteenable);
        3'd5: poly[63:32]  <= be_merge(poly[63:32],  csr_writedata, csr_byteenable);
        3'd6: seed[31:0]   <= be_merge(seed[31:0],   csr_writedata, csr_byteenable);
        3'd7: seed[63:32]  <= be_merge(seed[63:32],  csr_writedata, csr_byteenable);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csr_readdata <= 32'd0;
    end else if (csr_read) begin
      case (csr_address)
        3'd0: csr_readdata <= payload_len;
        3'd1: csr_readdata <= beat_cnt;
        3'd2: csr_readdata <= {7'd0, state == RUN, 14'd0, err_cnt != 32'd0,
                               state == DONE, 8'd0};
        3'd3: csr_readdata <= err_cnt;
        3'd4: csr_readdata <= poly[31:0];
        3'd5: csr_readdata <= poly[63:32];
        3'd6: csr_readdata <= seed[31:0];
        default: csr_readdata <= seed[63:32];
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_pattern_checker.sv
module tb_prbs_pattern_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  csr_address = '0;
  logic [31:0] csr_writedata = '0;
  logic        csr_write = 1'b0;
  logic        csr_read = 1'b0;
  logic [3:0]  csr_byteenable = '0;
  logic [31:0] csr_readdata;
  logic [31:0] snk_data = '0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;

  prbs_pattern_checker #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_writedata(csr_writedata),
    .csr_write(csr_write), .csr_read(csr_read),
    .csr_byteenable(csr_byteenable), .csr_readdata(csr_readdata),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { string tag; logic [31:0] exp; } sb_t;
  sb_t sb_q[$];

  logic [63:0] m_s, m_poly, m_seed;

`ifdef PRBS_CHK_BIT_ERR_EN
  localparam logic [31:0] INJ_ERRS = 32'd5;
`else
  localparam logic [31:0] INJ_ERRS = 32'd2;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_adv(input logic [63:0] s, input logic [63:0] p);
    logic [63:0] r;
    r = s;
    for (int i = 0; i < 32; i++) r = {r[62:0], ^(r & p)};
    return r;
  endfunction

  // All bus tasks start and end at a falling edge.
  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    csr_write = 1'b1; csr_address = a; csr_writedata = d; csr_byteenable = be;
    @(negedge clk);
    csr_write = 1'b0; csr_byteenable = 4'h0;
  endtask

  task automatic csr_rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    sb_t e;
    csr_read = 1'b1; csr_address = a;
    sb_q.push_back('{tag, exp});
    @(negedge clk);
    csr_read = 1'b0;
    e = sb_q.pop_front();
    chk(e.tag, csr_readdata, e.exp);
  endtask

  task automatic do_start();
    csr_wr(3'd2, 32'h0100_0000, 4'b1000);
    m_s = m_seed;
  endtask

  // Offer one beat (model word XOR flip) and hold until accepted; valid stays high.
  task automatic beat(input logic [31:0] flip);
    int to;
    snk_valid = 1'b1;
    snk_data  = m_s[31:0] ^ flip;
    to = 0;
    while (!snk_ready && to < 20) begin
      @(negedge clk);
      to++;
    end
    if (to >= 20) chk("ready_timeout", {31'd0, snk_ready}, 32'd1);
    @(negedge clk);
    m_s = m_adv(m_s, m_poly);
  endtask

  initial begin
    // 1 reset
    repeat (3) @(posedge clk);
    #1 chk("rst_ready", {31'd0, snk_ready}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    csr_rd(3'd0, 32'd0, "rst_len");
    csr_rd(3'd1, 32'd0, "rst_beats");
    csr_rd(3'd3, 32'd0, "rst_errs");
    csr_rd(3'd6, 32'd1, "rst_seed");

    // 2 clean run, length written with a single byte lane
    m_poly = 64'h0000_0000_6000_0000; m_seed = 64'h1;
    csr_wr(3'd4, 32'h6000_0000, 4'hF);
    csr_wr(3'd5, 32'h0, 4'hF);
    csr_wr(3'd6, 32'h1, 4'hF);
    csr_wr(3'd7, 32'h0, 4'hF);
    csr_wr(3'd0, 32'hAAAA_AA20, 4'b0001);
    csr_rd(3'd0, 32'd32, "be_len");
    do_start();
    for (int i = 0; i < 32; i++) beat(32'h0);
    chk("t2_ready_after_last", {31'd0, snk_ready}, 32'd0);
    @(negedge clk);              // beat still offered, must not be consumed
    snk_valid = 1'b0;
    csr_rd(3'd1, 32'd32, "t2_beats");
    csr_rd(3'd3, 32'd0, "t2_errs");
    csr_rd(3'd2, 32'h0000_0100, "t2_ctrl");

    // 3 error injection (restart from DONE)
    do_start();
    for (int i = 0; i < 32; i++)
      beat(i == 4 ? 32'h1 : (i == 19 ? 32'hF : 32'h0));
    snk_valid = 1'b0;
    csr_rd(3'd1, 32'd32, "t3_beats");
    csr_rd(3'd3, INJ_ERRS, "t3_errs");
    csr_rd(3'd2, 32'h0000_0300, "t3_ctrl");

    // 4 gaps on valid
    csr_wr(3'd0, 32'd16, 4'hF);
    do_start();
    for (int i = 0; i < 16; i++) begin
      snk_valid = 1'b0;
      @(negedge clk);
      beat(32'h0);
    end
    snk_valid = 1'b0;
    csr_rd(3'd1, 32'd16, "t4_beats");
    csr_rd(3'd3, 32'd0, "t4_errs");

    // 5 continuous then stop
    csr_wr(3'd0, 32'd0, 4'hF);
    do_start();
    for (int i = 0; i < 100; i++) beat(32'h0);
    snk_valid = 1'b0;
    csr_rd(3'd2, 32'h0100_0000, "t5_running");
    csr_wr(3'd2, 32'h0200_0000, 4'b1000);
    chk("t5_ready_after_stop", {31'd0, snk_ready}, 32'd0);
    csr_rd(3'd1, 32'd100, "t5_beats");
    csr_rd(3'd2, 32'h0, "t5_ctrl");

    // 6 restart mid-run, shadowed seed, clear
    do_start();
    for (int i = 0; i < 10; i++) beat(i == 3 ? 32'h80 : 32'h0);
    snk_valid = 1'b0;
    do_start();
    csr_rd(3'd1, 32'd0, "t6_restart_beats");
    csr_rd(3'd3, 32'd0, "t6_restart_errs");
    csr_wr(3'd6, 32'h5, 4'hF);   // must not disturb the running sequence
    for (int i = 0; i < 5; i++) beat(32'h0);
    snk_valid = 1'b0;
    csr_rd(3'd1, 32'd5, "t6_beats");
    csr_rd(3'd3, 32'd0, "t6_shadow_errs");
    csr_rd(3'd6, 32'h5, "t6_seed_rd");
    csr_wr(3'd2, 32'h1, 4'b0001);
    csr_rd(3'd1, 32'd0, "t6_clear_beats");

    // reset mid-run with new seed in effect
    m_seed = 64'h5;
    csr_wr(3'd0, 32'd7, 4'hF);
    do_start();
    for (int i = 0; i < 3; i++) beat(i == 1 ? 32'h1 : 32'h0);
    csr_rd(3'd3, 32'd1, "t6_pre_rst_errs");
    snk_valid = 1'b1;
    reset = 1'b0;
    #1 chk("t6_rst_ready", {31'd0, snk_ready}, 32'd0);
    @(negedge clk);
    snk_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_ready_idle", {31'd0, snk_ready}, 32'd0);
    csr_rd(3'd0, 32'd0, "t6_rst_len");
    csr_rd(3'd1, 32'd0, "t6_rst_beats");
    csr_rd(3'd3, 32'd0, "t6_rst_errs");
    csr_rd(3'd2, 32'd0, "t6_rst_ctrl");
    csr_rd(3'd4, 32'd0, "t6_rst_poly");
    csr_rd(3'd6, 32'd1, "t6_rst_seed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
